// File: rtl/core_pkg.sv
// Shared RV32IMC core definitions: default datapath widths, the bubble
// instruction, the IF/ID payload layout and the IF/ID occupancy encoding.
package core_pkg;

    localparam int CORE_PC_W   = 12;
    localparam int CORE_INST_W = 32;

    // addi x0, x0, 0
    localparam logic [CORE_INST_W-1:0] NOP_INST_RV32 = 32'h00000013;

    typedef struct packed {
        logic [CORE_PC_W-1:0]   pc4;
        logic [CORE_INST_W-1:0] inst;
        logic [CORE_PC_W-1:0]   PC;
    } if_id_payload_t;

    localparam int IF_ID_PAYLOAD_W = $bits(if_id_payload_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } if_id_occ_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: a valid bit plus a payload register. Clear wins over
// load and returns the payload to the bubble pattern.
module pipe_slot #(
    parameter int           W      = 56,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (clear) begin
            valid <= 1'b0;
            q     <= BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID boundary with a 2-entry skid buffer: if_ready is a flop, so a decode
// stall never creates a combinational path back into fetch.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | OUT and SKID empty; id_* shows the NOP bubble
// ST_ONE   | OUT live, SKID empty; fetch may still issue
// ST_FULL  | OUT and SKID live; if_ready low until SKID drains
module if_id_skid
    import core_pkg::*;
#(
    parameter int                PC_W     = CORE_PC_W,
    parameter int                INST_W   = CORE_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_RV32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [PC_W-1:0]   if_pc4,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_PC,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [PC_W-1:0]   id_pc4,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_PC,
    output logic              skid_full
);

    localparam int PW = 2 * PC_W + INST_W;
    localparam logic [PW-1:0] BUBBLE = {{PC_W{1'b0}}, NOP_INST, {PC_W{1'b0}}};

    if_id_occ_e state_q, state_d;

    logic          out_valid, skid_valid;
    logic [PW-1:0] out_q, skid_q, in_pl, out_d;
    logic          out_load, out_clr, skid_load, skid_clr, out_from_skid;
    logic          acc, con;

    assign in_pl = {if_pc4, if_inst, if_PC};
    assign acc   = if_valid & if_ready;
    assign con   = out_valid & id_ready;
    assign out_d = out_from_skid ? skid_q : in_pl;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        out_load      = 1'b0;
        out_clr       = 1'b0;
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            // Redirect: drop everything, including whatever fetch offers now.
            out_clr  = 1'b1;
            skid_clr = 1'b1;
            state_d  = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        out_load = 1'b1;
                        state_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (con && acc) begin
                        out_load = 1'b1;
                    end else if (con) begin
                        out_clr = 1'b1;
                        state_d = ST_EMPTY;
                    end else if (acc) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    // if_ready is low here, so only the drain path exists.
                    if (con) begin
                        out_load      = 1'b1;
                        out_from_skid = 1'b1;
                        skid_clr      = 1'b1;
                        state_d       = ST_ONE;
                    end
                end
                default: begin
                    out_clr  = 1'b1;
                    skid_clr = 1'b1;
                    state_d  = ST_EMPTY;
                end
            endcase
        end
    end

    pipe_slot #(.W(PW), .BUBBLE(BUBBLE)) u_out (
        .clk   (clk),
        .nrst  (nrst),
        .load  (out_load),
        .clear (out_clr),
        .d     (out_d),
        .valid (out_valid),
        .q     (out_q)
    );

    pipe_slot #(.W(PW), .BUBBLE(BUBBLE)) u_skid (
        .clk   (clk),
        .nrst  (nrst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_pl),
        .valid (skid_valid),
        .q     (skid_q)
    );

    assign {id_pc4, id_inst, id_PC} = out_q;
    assign id_valid  = out_valid;
    assign skid_full = skid_valid;
    assign if_ready  = ~skid_valid;

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: a 2-deep FIFO queue model checked every cycle, plus
// directed sequences with literal expectations and a long random run.
module tb_if_id_skid;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_valid, if_ready, flush, id_valid, id_ready, skid_full;
    logic [11:0] if_pc4, if_PC, id_pc4, id_PC;
    logic [31:0] if_inst, id_inst;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    bit m_acc, m_con;
    if_id_payload_t q[$];
    if_id_payload_t exp_pl;

    if_id_skid dut (
        .clk       (clk),
        .nrst      (nrst),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc4    (if_pc4),
        .if_inst   (if_inst),
        .if_PC     (if_PC),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_pc4    (id_pc4),
        .id_inst   (id_inst),
        .id_PC     (id_PC),
        .skid_full (skid_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input logic [11:0] pc, input bit rdy, input bit fl);
        if_valid = v;
        if_PC    = pc;
        if_pc4   = 12'(pc + 12'd4);
        if_inst  = {8'hC0, 12'h000, pc};
        id_ready = rdy;
        flush    = fl;
    endtask

    // Model: a FIFO of at most two instructions; fetch is accepted only when
    // fewer than two are held at the start of the cycle.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            q.delete();
        end else begin
            m_acc = if_valid && (q.size() < 2);
            m_con = (q.size() > 0) && id_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (m_con) void'(q.pop_front());
                if (m_acc) q.push_back('{pc4: if_pc4, inst: if_inst, PC: if_PC});
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_pl = (q.size() > 0) ? q[0] : '{pc4: '0, inst: NOP_INST_RV32, PC: '0};
            chk("m_id_valid",  32'(id_valid),  32'(q.size() > 0));
            chk("m_id_inst",   id_inst,        exp_pl.inst);
            chk("m_id_pc4",    32'(id_pc4),    32'(exp_pl.pc4));
            chk("m_id_PC",     32'(id_PC),     32'(exp_pl.PC));
            chk("m_if_ready",  32'(if_ready),  32'(q.size() < 2));
            chk("m_skid_full", 32'(skid_full), 32'(q.size() == 2));
            chk("m_illegal",   32'(skid_full & ~id_valid), 32'd0);
        end
    end

    initial begin
        nrst = 1'b0;
        set_in(1'b1, 12'h000, 1'b1, 1'b0);
        if_inst = 32'h00A00093;
        repeat (3) @(negedge clk);
        chk("rst_id_valid",  32'(id_valid),  32'd0);
        chk("rst_id_inst",   id_inst,        32'h00000013);
        chk("rst_id_pc4",    32'(id_pc4),    32'd0);
        chk("rst_if_ready",  32'(if_ready),  32'd1);
        chk("rst_skid_full", 32'(skid_full), 32'd0);
        nrst   = 1'b1;
        chk_en = 1'b1;
        set_in(1'b0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);

        // Back-to-back streaming, one cycle latency.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 12'(4 * i), 1'b1, 1'b0);
            @(negedge clk);
            chk("stream_valid", 32'(id_valid), 32'd1);
            chk("stream_PC",    32'(id_PC),    32'(4 * i));
            chk("stream_pc4",   32'(id_pc4),   32'(4 * i + 4));
        end
        set_in(1'b0, 12'h000, 1'b1, 1'b0);
        @(negedge clk);
        chk("stream_end_valid", 32'(id_valid), 32'd0);

        // Stall with A then B: B lands in SKID, fetch is held off.
        set_in(1'b1, 12'h010, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_A_PC",   32'(id_PC),     32'h010);
        chk("stall_A_rdy",  32'(if_ready),  32'd1);
        set_in(1'b1, 12'h014, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_hold_PC", 32'(id_PC),     32'h010);
        chk("stall_skid",    32'(skid_full), 32'd1);
        chk("stall_rdy",     32'(if_ready),  32'd0);
        set_in(1'b0, 12'h018, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_hold2_PC", 32'(id_PC), 32'h010);
        set_in(1'b0, 12'h018, 1'b1, 1'b0);
        @(negedge clk);
        chk("drain_B_PC",  32'(id_PC),    32'h014);
        chk("drain_rdy",   32'(if_ready), 32'd1);
        @(negedge clk);
        chk("drain_empty", 32'(id_valid), 32'd0);

        // Flush while FULL with C on the input: nothing survives.
        set_in(1'b1, 12'h020, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 12'h024, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_pre_skid", 32'(skid_full), 32'd1);
        set_in(1'b1, 12'h028, 1'b0, 1'b1);
        @(negedge clk);
        chk("fl_valid", 32'(id_valid),  32'd0);
        chk("fl_inst",  id_inst,        32'h00000013);
        chk("fl_skid",  32'(skid_full), 32'd0);
        set_in(1'b0, 12'h000, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("fl_gone", 32'(id_valid), 32'd0);
        end

        // Async reset in FULL, observed before the next rising edge.
        set_in(1'b1, 12'h030, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 12'h034, 1'b0, 1'b0);
        @(negedge clk);
        chk("ar_pre_skid", 32'(skid_full), 32'd1);
        set_in(1'b0, 12'h000, 1'b0, 1'b0);
        #2 nrst = 1'b0;
        #1;
        chk("ar_valid", 32'(id_valid),  32'd0);
        chk("ar_inst",  id_inst,        32'h00000013);
        chk("ar_skid",  32'(skid_full), 32'd0);
        chk("ar_rdy",   32'(if_ready),  32'd1);
        @(negedge clk);
        nrst = 1'b1;

        // Random traffic with ~5% flush.
        for (int n = 0; n < 10000; n++) begin
            set_in($urandom_range(99) < 65, 12'($urandom_range(4095)),
                   $urandom_range(99) < 60, $urandom_range(99) < 5);
            if_inst = $urandom;
            @(negedge clk);
        end
        set_in(1'b0, 12'h000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("final_empty", 32'(id_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
